// File: rtl/led_bar_sequencer.sv
// LED bar fill sequencer: ramps a 0-4 nibble fill level toward a latched target
// one step per tick, with an alarm-driven blink sequence that preempts ramping.
module led_bar_sequencer #(
    parameter int BLINK_TICKS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [2:0]  target,
    input  logic        load,
    input  logic        alarm,
    output logic [15:0] led,
    output logic [2:0]  level,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int CW = $clog2(BLINK_TICKS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        BLINK = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [2:0]      level_n, target_q, target_q_n, tgt_sat;
    logic [CW-1:0]   blink_cnt, blink_cnt_n;
    logic            phase, phase_n;
    logic [15:0]     led_n;
    logic            busy_n;

    function automatic logic [15:0] fill(input logic [2:0] lv);
        case (lv)
            3'd0:    fill = 16'h0000;
            3'd1:    fill = 16'h000F;
            3'd2:    fill = 16'h00FF;
            3'd3:    fill = 16'h0FFF;
            default: fill = 16'hFFFF;
        endcase
    endfunction

    assign tgt_sat   = (target > 3'd4) ? 3'd4 : target;
    assign state_dbg = state;

    always_comb begin
        state_n     = state;
        level_n     = level;
        target_q_n  = target_q;
        blink_cnt_n = blink_cnt;
        phase_n     = phase;

        if (load) target_q_n = tgt_sat;

        if (alarm) begin
            state_n     = BLINK;
            blink_cnt_n = '0;
            phase_n     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load && (tgt_sat != level)) state_n = RAMP;
                end
                RAMP: begin
                    // A same-cycle load retargets before the step is taken.
                    if (target_q_n == level) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        level_n = (target_q_n > level) ? level + 3'd1 : level - 3'd1;
                        if (level_n == target_q_n) state_n = IDLE;
                    end
                end
                BLINK: begin
                    if (tick) begin
                        phase_n     = ~phase;
                        blink_cnt_n = blink_cnt + 1'b1;
                        if (blink_cnt == LAST_CNT) begin
                            state_n     = (target_q_n != level) ? RAMP : IDLE;
                            blink_cnt_n = '0;
                            phase_n     = 1'b0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        led_n  = (state_n == BLINK) ? (phase_n ? 16'hFFFF : 16'h0000) : fill(level_n);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            level     <= 3'd0;
            target_q  <= 3'd0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            led       <= 16'h0000;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            level     <= level_n;
            target_q  <= target_q_n;
            blink_cnt <= blink_cnt_n;
            phase     <= phase_n;
            led       <= led_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_led_bar_sequencer.sv
// Directed bench for led_bar_sequencer: hand-computed led/level/busy after
// each clock edge, covering ramping, saturation, retarget, blink and reset.
module tb_led_bar_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick, load, alarm;
    logic [2:0]  target;
    logic [15:0] led;
    logic [2:0]  level;
    logic        busy;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    led_bar_sequencer #(.BLINK_TICKS(6)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .target(target), .load(load),
        .alarm(alarm), .led(led), .level(level), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] e_led,
                              input logic [2:0] e_lvl, input logic e_busy);
        check({tag, ".led"}, led, e_led);
        check({tag, ".level"}, 16'(level), 16'(e_lvl));
        check({tag, ".busy"}, 16'(busy), 16'(e_busy));
    endtask

    // Drive one cycle of inputs around a rising edge; outputs are sampled #1 after it.
    task automatic cycle(input logic t, input logic l, input logic [2:0] tg, input logic a);
        @(negedge clk);
        tick = t; load = l; target = tg; alarm = a;
        @(posedge clk);
        #1;
        tick = 1'b0; load = 1'b0; alarm = 1'b0;
    endtask

    // n blink ticks that do not end the sequence; bar alternates starting dark.
    task automatic blink_run(input string tag, input int n, input logic [2:0] lvl);
        for (int i = 0; i < n; i++) begin
            cycle(1, 0, 0, 0);
            expect_out(tag, (i % 2 == 0) ? 16'h0000 : 16'hFFFF, lvl, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; load = 1'b0; alarm = 1'b0; target = 3'd0;
        #12;
        expect_out("reset", 16'h0000, 3'd0, 1'b0);
        check("reset.state", 16'(state_dbg), 16'd0);
        @(negedge clk); rst_n = 1'b1;

        // Saturating load then ramp up and back down
        cycle(0, 1, 3'd7, 0); expect_out("sat.load", 16'h0000, 3'd0, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("sat.t1", 16'h000F, 3'd1, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("sat.t2", 16'h00FF, 3'd2, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("sat.t3", 16'h0FFF, 3'd3, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("sat.t4", 16'hFFFF, 3'd4, 1'b0);
        cycle(0, 1, 3'd1, 0); expect_out("down.load", 16'hFFFF, 3'd4, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("down.t1", 16'h0FFF, 3'd3, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("down.t2", 16'h00FF, 3'd2, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("down.t3", 16'h000F, 3'd1, 1'b0);
        cycle(0, 1, 3'd0, 0); expect_out("zero.load", 16'h000F, 3'd1, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("zero.t1", 16'h0000, 3'd0, 1'b0);

        // Ramp up to 3, extra tick holds; reload of current level stays idle
        cycle(1, 1, 3'd3, 0); expect_out("up.load_tick", 16'h0000, 3'd0, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("up.t1", 16'h000F, 3'd1, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("up.t2", 16'h00FF, 3'd2, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("up.t3", 16'h0FFF, 3'd3, 1'b0);
        cycle(1, 0, 0, 0);    expect_out("up.extra", 16'h0FFF, 3'd3, 1'b0);
        cycle(0, 1, 3'd3, 0); expect_out("same.load", 16'h0FFF, 3'd3, 1'b0);
        cycle(0, 1, 3'd0, 0); expect_out("to0.load", 16'h0FFF, 3'd3, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("to0.t1", 16'h00FF, 3'd2, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("to0.t2", 16'h000F, 3'd1, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("to0.t3", 16'h0000, 3'd0, 1'b0);

        // Mid-ramp retarget downward
        cycle(0, 1, 3'd4, 0); expect_out("rt.load", 16'h0000, 3'd0, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("rt.t1", 16'h000F, 3'd1, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("rt.t2", 16'h00FF, 3'd2, 1'b1);
        cycle(0, 1, 3'd0, 0); expect_out("rt.load0", 16'h00FF, 3'd2, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("rt.t3", 16'h000F, 3'd1, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("rt.t4", 16'h0000, 3'd0, 1'b0);

        // Load of the current level mid-ramp returns to idle without a tick
        cycle(0, 1, 3'd4, 0); expect_out("cur.load", 16'h0000, 3'd0, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("cur.t1", 16'h000F, 3'd1, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("cur.t2", 16'h00FF, 3'd2, 1'b1);
        cycle(0, 1, 3'd2, 0); expect_out("cur.load2", 16'h00FF, 3'd2, 1'b0);

        // Alarm at level 2 while ramping to 4
        cycle(0, 1, 3'd4, 0); expect_out("al.load", 16'h00FF, 3'd2, 1'b1);
        cycle(0, 0, 0, 1);    expect_out("al.enter", 16'hFFFF, 3'd2, 1'b1);
        check("al.state", 16'(state_dbg), 16'd2);
        blink_run("al.blink", 5, 3'd2);
        cycle(1, 0, 0, 0);    expect_out("al.exit", 16'h00FF, 3'd2, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("al.r1", 16'h0FFF, 3'd3, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("al.r2", 16'hFFFF, 3'd4, 1'b0);

        // Alarm with tick in the same cycle: that tick is not counted
        cycle(1, 0, 0, 1);    expect_out("at.enter", 16'hFFFF, 3'd4, 1'b1);
        blink_run("at.blink", 5, 3'd4);
        cycle(1, 0, 0, 0);    expect_out("at.exit", 16'hFFFF, 3'd4, 1'b0);

        // Alarm restart at blink tick 4, plus a load during blink
        cycle(0, 0, 0, 1);    expect_out("rs.enter", 16'hFFFF, 3'd4, 1'b1);
        blink_run("rs.pre", 4, 3'd4);
        cycle(0, 0, 0, 1);    expect_out("rs.restart", 16'hFFFF, 3'd4, 1'b1);
        cycle(0, 1, 3'd1, 0); expect_out("rs.load", 16'hFFFF, 3'd4, 1'b1);
        blink_run("rs.blink", 5, 3'd4);
        cycle(1, 0, 0, 0);    expect_out("rs.exit", 16'hFFFF, 3'd4, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("rs.r1", 16'h0FFF, 3'd3, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("rs.r2", 16'h00FF, 3'd2, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("rs.r3", 16'h000F, 3'd1, 1'b0);
        cycle(0, 1, 3'd0, 0); expect_out("rs.load0", 16'h000F, 3'd1, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("rs.r4", 16'h0000, 3'd0, 1'b0);

        // Simultaneous load 4 and alarm from idle at level 0
        cycle(0, 1, 3'd4, 1); expect_out("la.enter", 16'hFFFF, 3'd0, 1'b1);
        blink_run("la.blink", 5, 3'd0);
        cycle(1, 0, 0, 0);    expect_out("la.exit", 16'h0000, 3'd0, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("la.r1", 16'h000F, 3'd1, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("la.r2", 16'h00FF, 3'd2, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("la.r3", 16'h0FFF, 3'd3, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("la.r4", 16'hFFFF, 3'd4, 1'b0);

        // Asynchronous reset mid-ramp at level 2
        cycle(0, 1, 3'd0, 0); expect_out("ar.load", 16'hFFFF, 3'd4, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("ar.t1", 16'h0FFF, 3'd3, 1'b1);
        cycle(1, 0, 0, 0);    expect_out("ar.t2", 16'h00FF, 3'd2, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 expect_out("ar.async", 16'h0000, 3'd0, 1'b0);
        check("ar.state", 16'(state_dbg), 16'd0);
        @(negedge clk); rst_n = 1'b1;
        cycle(1, 0, 0, 0);    expect_out("ar.post1", 16'h0000, 3'd0, 1'b0);
        cycle(1, 0, 0, 0);    expect_out("ar.post2", 16'h0000, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
